// File: rtl/pipe_pkg.sv
// Shared types and widths for the elastic pipeline stage and its statistics counters.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_BUSY  = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_e;

    localparam int OCC_W  = 2;
    localparam int STAT_W = 32;

    function automatic logic [OCC_W-1:0] state_occ(input pipe_state_e s);
        case (s)
            PS_BUSY: state_occ = 2'd1;
            PS_FULL: state_occ = 2'd2;
            default: state_occ = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int W = STAT_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: main register plus one skid entry, registered in_ready, synchronous flush.
// Optional stall/bubble statistics are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W         = 64,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cycles,
    output logic [STAT_W-1:0] bubble_cycles
`endif
);

    pipe_state_e       r_state;
    pipe_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              r_in_ready;
    logic              w_out_valid;
    logic              w_in_fire;
    logic              w_out_fire;

    // An unknown encoding is treated as empty so nothing is emitted while it recovers.
    assign w_out_valid = (r_state == PS_BUSY) || (r_state == PS_FULL);
    assign w_in_fire   = in_valid & r_in_ready;
    assign w_out_fire  = w_out_valid & out_ready & ~stall;

    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main;
        w_skid_nxt  = r_skid;
        case (r_state)
            PS_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = PS_BUSY;
                    w_main_nxt  = in_data;
                end
            end
            PS_BUSY: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_nxt = in_data;
                end else if (w_in_fire) begin
                    w_state_nxt = PS_FULL;
                    w_skid_nxt  = in_data;
                end else if (w_out_fire) begin
                    w_state_nxt = PS_EMPTY;
                end
            end
            PS_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt = PS_BUSY;
                    w_main_nxt  = r_skid;
                end
            end
            default: w_state_nxt = PS_EMPTY;
        endcase
        if (flush) begin
            w_state_nxt = PS_EMPTY;
            if (CLEAR_ON_FLUSH) begin
                w_main_nxt = '0;
                w_skid_nxt = '0;
            end
        end
    end

    // in_ready is derived from the next state so out_ready never reaches it combinationally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= PS_EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_main     <= w_main_nxt;
            r_skid     <= w_skid_nxt;
            r_in_ready <= (w_state_nxt != PS_FULL);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_main;
    assign occupancy = state_occ(r_state);

`ifdef PIPE_STAGE_STATS_EN
    logic w_stall_inc;
    logic w_bubble_inc;

    assign w_stall_inc  = w_out_valid & ~(out_ready & ~stall);
    assign w_bubble_inc = ~w_out_valid & ~flush;

    pipe_sat_counter #(.W(STAT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_stall_inc),
        .i_clr   (flush),
        .o_count (stall_cycles)
    );

    pipe_sat_counter #(.W(STAT_W)) u_bubble_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_bubble_inc),
        .i_clr   (flush),
        .o_count (bubble_cycles)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: cycle vector table, FIFO scoreboard monitor, hand-written corner sequences.
// Statistics checks are compiled only when PIPE_STAGE_STATS_EN is defined.
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush, stall, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_STAGE_STATS_EN
    logic [31:0]   stall_cycles, bubble_cycles;
`endif

    int checks = 0;
    int errors = 0;
    logic          mon_en = 1'b0;
    logic [DW-1:0] sb[$];

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .stall         (stall),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
`ifdef PIPE_STAGE_STATS_EN
        .occupancy     (occupancy),
        .stall_cycles  (stall_cycles),
        .bubble_cycles (bubble_cycles)
`else
        .occupancy     (occupancy)
`endif
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic st, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: inputs settle 1 time unit after posedge, so negedge sees what the next edge will act on.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else if (mon_en) begin
            check("sb_occ", {62'd0, occupancy}, DW'(sb.size()));
            check("sb_valid", {63'd0, out_valid}, {63'd0, (sb.size() != 0)});
            check("sb_ready", {63'd0, in_ready}, {63'd0, (sb.size() < 2)});
            if (sb.size() != 0) check("sb_data", out_data, sb[0]);
            if (out_valid && out_ready && !stall) begin
                if (sb.size() == 0) check("sb_unexpected_beat", out_data, {DW{1'b1}});
                else void'(sb.pop_front());
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back(in_data);
        end
    end

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          st;
        logic          fl;
        logic          ov;
        logic          chk_d;
        logic [DW-1:0] od;
        logic          ir;
        logic [1:0]    occ;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic iv, input logic [DW-1:0] d, input logic ordy,
                                input logic st, input logic fl, input logic ov,
                                input logic chk_d, input logic [DW-1:0] od,
                                input logic ir, input logic [1:0] occ);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.st = st; v.fl = fl;
        v.ov = ov; v.chk_d = chk_d; v.od = od; v.ir = ir; v.occ = occ;
        vecs.push_back(v);
    endfunction

    initial begin
        //  iv  data    ordy st fl | ov chk od    ir occ   (outputs after the edge)
        add(1, 64'hA,  0, 0, 0,    1, 1, 64'hA,  1, 1);
        add(1, 64'hB,  0, 0, 0,    1, 1, 64'hA,  0, 2);
        add(0, 64'h0,  0, 0, 0,    1, 1, 64'hA,  0, 2);
        add(0, 64'h0,  1, 0, 0,    1, 1, 64'hB,  1, 1);
        add(0, 64'h0,  1, 0, 0,    0, 0, 64'h0,  1, 0);
        add(1, 64'h1,  0, 0, 0,    1, 1, 64'h1,  1, 1);
        add(1, 64'h2,  0, 0, 0,    1, 1, 64'h1,  0, 2);
        add(1, 64'hC,  0, 0, 1,    0, 1, 64'h0,  1, 0);
        add(0, 64'h0,  1, 0, 0,    0, 1, 64'h0,  1, 0);
        add(1, 64'h3,  0, 0, 0,    1, 1, 64'h3,  1, 1);
        add(1, 64'hC,  0, 0, 1,    0, 1, 64'h0,  1, 0);
        add(1, 64'h5,  0, 0, 0,    1, 1, 64'h5,  1, 1);
        add(0, 64'h0,  1, 1, 0,    1, 1, 64'h5,  1, 1);
        add(0, 64'h0,  1, 1, 0,    1, 1, 64'h5,  1, 1);
        add(0, 64'h0,  1, 1, 0,    1, 1, 64'h5,  1, 1);
        add(0, 64'h0,  1, 0, 0,    0, 0, 64'h0,  1, 0);
        add(0, 64'h0,  1, 0, 0,    0, 0, 64'h0,  1, 0);
        add(1, 64'h6,  1, 1, 0,    1, 1, 64'h6,  1, 1);
        add(1, 64'h7,  1, 1, 0,    1, 1, 64'h6,  0, 2);
        add(1, 64'h8,  1, 1, 0,    1, 1, 64'h6,  0, 2);
        add(0, 64'h0,  1, 0, 0,    1, 1, 64'h7,  1, 1);
        add(0, 64'h0,  1, 0, 0,    0, 0, 64'h0,  1, 0);
        add(1, 64'h9,  1, 0, 0,    1, 1, 64'h9,  1, 1);
        add(1, 64'h10, 1, 0, 0,    1, 1, 64'h10, 1, 1);
        add(0, 64'h0,  1, 0, 0,    0, 0, 64'h0,  1, 0);

        reset = 1'b1;
        drive(0, '0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_occ", {62'd0, occupancy}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        mon_en = 1'b1;

        // Full-rate streaming
        for (int i = 1; i <= 8; i++) begin
            drive(1, DW'(i), 1, 0, 0);
            step();
            check("stream_valid", {63'd0, out_valid}, 64'd1);
            check("stream_data", out_data, DW'(i));
            check("stream_in_ready", {63'd0, in_ready}, 64'd1);
        end
        drive(0, '0, 1, 0, 0);
        step();
        check("stream_drained", {63'd0, out_valid}, 64'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].st, vecs[i].fl);
            step();
            check($sformatf("vec%0d_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].ov});
            check($sformatf("vec%0d_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].ir});
            check($sformatf("vec%0d_occ", i), {62'd0, occupancy}, {62'd0, vecs[i].occ});
            if (vecs[i].chk_d) check($sformatf("vec%0d_data", i), out_data, vecs[i].od);
        end

        // Asynchronous reset while FULL
        drive(1, 64'hD1, 0, 0, 0);
        step();
        drive(1, 64'hD2, 0, 0, 0);
        step();
        check("pre_rst_occ", {62'd0, occupancy}, 64'd2);
        drive(0, '0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_ready", {63'd0, in_ready}, 64'd1);
        check("async_rst_data", out_data, 64'd0);
        check("async_rst_occ", {62'd0, occupancy}, 64'd0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_valid", {63'd0, out_valid}, 64'd0);

`ifdef PIPE_STAGE_STATS_EN
        drive(0, '0, 0, 0, 1);
        step();
        check("stat_flush_stall", {32'd0, stall_cycles}, 64'd0);
        check("stat_flush_bubble", {32'd0, bubble_cycles}, 64'd0);
        // Loading the beat costs one bubble; two held cycles by out_ready=0 and two by stall.
        drive(1, 64'h11, 0, 0, 0);
        step();
        drive(0, '0, 0, 0, 0);
        repeat (2) step();
        drive(0, '0, 1, 1, 0);
        repeat (2) step();
        drive(0, '0, 1, 0, 0);
        step();
        repeat (3) step();
        check("stat_stall", {32'd0, stall_cycles}, 64'd4);
        check("stat_bubble", {32'd0, bubble_cycles}, 64'd4);
        drive(0, '0, 1, 0, 1);
        step();
        check("stat_clr_stall", {32'd0, stall_cycles}, 64'd0);
        check("stat_clr_bubble", {32'd0, bubble_cycles}, 64'd0);
        drive(0, '0, 1, 0, 0);
        step();
`endif

        check("sb_empty_at_end", DW'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
